// File: rtl/mode_seq_pkg.sv
// rtl/mode_seq_pkg.sv - mode/controller encodings and the legal-transition rule for mode_sequencer
package mode_seq_pkg;

  typedef enum logic [2:0] {
    MODE_OFF   = 3'd0,
    MODE_INIT  = 3'd1,
    MODE_RUN   = 3'd2,
    MODE_PAUSE = 3'd3,
    MODE_FAULT = 3'd4
  } mode_t;

  typedef enum logic [1:0] {
    CTRL_IDLE   = 2'd0,
    CTRL_CHECK  = 2'd1,
    CTRL_SETTLE = 2'd2,
    CTRL_RESP   = 2'd3
  } ctrl_state_t;

  function automatic logic is_defined(input logic [2:0] m);
    return m <= MODE_FAULT;
  endfunction

  // OFF is reachable from anywhere; FAULT and codes 5..7 are never legal targets.
  function automatic logic is_legal(input logic [2:0] cur, input logic [2:0] nxt);
    return (nxt == MODE_OFF) ||
           (cur == MODE_OFF   && nxt == MODE_INIT) ||
           (cur == MODE_INIT  && nxt == MODE_RUN) ||
           (cur == MODE_RUN   && nxt == MODE_PAUSE) ||
           (cur == MODE_PAUSE && nxt == MODE_RUN);
  endfunction

endpackage

// File: rtl/mode_sequencer_if.sv
// rtl/mode_sequencer_if.sv - request/response handshake between requesters and mode_sequencer
interface mode_seq_if;
  logic       req_valid;
  logic [2:0] req_mode;
  logic       req_ready;
  logic       rsp_valid;
  logic       rsp_ok;

  modport master (output req_valid, req_mode, input req_ready, rsp_valid, rsp_ok);
  modport slave  (input req_valid, req_mode, output req_ready, rsp_valid, rsp_ok);
endinterface

// File: rtl/mode_sequencer_settle_timer.sv
// rtl/mode_sequencer_settle_timer.sv - settle_timer: loadable down-counter with a zero flag
module settle_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mode_sequencer.sv
// rtl/mode_sequencer.sv - guarded system mode FSM: check, settle, commit, respond.
// Optional MODE_SEQ_LOCK_EN adds a sticky lock (lock_req/locked) that rejects all requests.
module mode_sequencer
  import mode_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  mode_seq_if.slave        bus,
  input  logic             fault_in,
  output logic [2:0]       mode,
  output logic             busy,
  output logic [ERR_W-1:0] err_cnt
`ifdef MODE_SEQ_LOCK_EN
  ,
  input  logic             lock_req,
  output logic             locked
`endif
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  localparam logic [1:0] ST_IDLE   = CTRL_IDLE;
  localparam logic [1:0] ST_CHECK  = CTRL_CHECK;
  localparam logic [1:0] ST_SETTLE = CTRL_SETTLE;
  localparam logic [1:0] ST_RESP   = CTRL_RESP;

  logic [1:0]       state_q, state_d;
  logic [2:0]       mode_q, mode_d;
  logic [2:0]       pend_q, pend_d;
  logic             ok_q, ok_d;
  logic [ERR_W-1:0] err_q, err_d, err_inc;
  logic             tmr_load, tmr_dec, tmr_zero;
  logic             commit;
  logic             lock_block;

`ifdef MODE_SEQ_LOCK_EN
  logic locked_q, locked_d;

  always_comb begin
    locked_d = locked_q;
    if (lock_req && mode_q == MODE_RUN && state_q == ST_IDLE) begin
      locked_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      locked_q <= 1'b0;
    end else begin
      locked_q <= locked_d;
    end
  end

  assign locked     = locked_q;
  assign lock_block = locked_q;
`else
  assign lock_block = 1'b0;
`endif

  assign err_inc = (&err_q) ? err_q : err_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    ok_d     = ok_q;
    err_d    = err_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    commit   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          pend_d  = bus.req_mode;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        state_d = ST_RESP;
        ok_d    = 1'b0;
        // A fault abort is not the requester's error, so it is not counted.
        if (fault_in) begin
          ok_d = 1'b0;
        end else if (lock_block || !(pend_q == mode_q || is_legal(mode_q, pend_q))) begin
          err_d = err_inc;
        end else if (pend_q == mode_q) begin
          ok_d = 1'b1;
        end else begin
          tmr_load = 1'b1;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (fault_in) begin
          ok_d    = 1'b0;
          state_d = ST_RESP;
        end else if (tmr_zero) begin
          commit  = 1'b1;
          ok_d    = 1'b1;
          state_d = ST_RESP;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    mode_d = mode_q;
    if (fault_in || !is_defined(mode_q)) begin
      mode_d = MODE_FAULT;
    end else if (commit) begin
      mode_d = pend_q;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_OFF;
      pend_q  <= MODE_OFF;
      ok_q    <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      pend_q  <= pend_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  settle_timer #(.CNT_W(CNT_W)) u_settle_timer (
    .clk      (clk),
    .rst      (rst_n),
    .load     (tmr_load),
    .load_val (SETTLE_LOAD),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_ok    = (state_q == ST_RESP) && ok_q;
  assign busy          = (state_q == ST_CHECK) || (state_q == ST_SETTLE);
  assign mode          = mode_q;
  assign err_cnt       = err_q;

endmodule

// File: tb/tb_mode_sequencer.sv
// tb/tb_mode_sequencer.sv - self-checking bench for mode_sequencer (MODE_SEQ_LOCK_EN optional)
module tb_mode_sequencer;

  localparam int SETTLE = 4;
  localparam int EW     = 8;
  localparam int LAT_S  = 2 + SETTLE;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          fault_in = 1'b0;
  logic [2:0]    mode;
  logic          busy;
  logic [EW-1:0] err_cnt;
`ifdef MODE_SEQ_LOCK_EN
  logic          lock_req = 1'b0;
  logic          locked;
`endif

  mode_seq_if bus ();

  mode_sequencer #(.SETTLE_CYCLES(SETTLE), .ERR_W(EW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .fault_in (fault_in),
    .mode     (mode),
    .busy     (busy),
    .err_cnt  (err_cnt)
`ifdef MODE_SEQ_LOCK_EN
    ,
    .lock_req (lock_req),
    .locked   (locked)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0] req;
    logic       ok;
    int         lat;
    logic [2:0] mode_after;
    logic [7:0] err_after;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string name);
    check({name, "/ready"}, 32'(bus.req_ready), 32'd1);
    check({name, "/busy"}, 32'(busy), 32'd0);
    check({name, "/rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({name, "/rsp_ok"}, 32'(bus.rsp_ok), 32'd0);
    check({name, "/err_cnt"}, 32'(err_cnt), 32'd0);
    check({name, "/mode"}, 32'(mode), 32'd0);
  endtask

  // Called at a negedge with the controller idle; returns at the negedge after the response.
  task automatic do_req(input string name, input logic [2:0] m, input logic exp_ok,
                        input int exp_lat, input logic [2:0] exp_mode, input logic [7:0] exp_err);
    logic [2:0] m0;
    int         cyc;
    bit         seen;
    check({name, "/ready"}, 32'(bus.req_ready), 32'd1);
    m0 = mode;
    bus.req_valid = 1'b1;
    bus.req_mode  = m;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      bus.req_valid = 1'b0;
      if (bus.rsp_valid) begin
        seen = 1'b1;
      end else begin
        check({name, "/wait_ok"}, 32'(bus.rsp_ok), 32'd0);
        check({name, "/wait_busy"}, 32'(busy), 32'd1);
        check({name, "/wait_mode"}, 32'(mode), 32'(m0));
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s/timeout: got no rsp_valid within %0d cycles, required one", name, cyc);
    end else begin
      check({name, "/latency"}, 32'(cyc), 32'(exp_lat));
      check({name, "/rsp_ok"}, 32'(bus.rsp_ok), 32'(exp_ok));
      check({name, "/mode"}, 32'(mode), 32'(exp_mode));
      check({name, "/err_cnt"}, 32'(err_cnt), 32'(exp_err));
      check({name, "/resp_busy"}, 32'(busy), 32'd0);
      @(negedge clk);
      check({name, "/one_shot"}, 32'(bus.rsp_valid), 32'd0);
      check({name, "/ready_again"}, 32'(bus.req_ready), 32'd1);
    end
  endtask

  task automatic quick_req(input logic [2:0] m);
    int cyc;
    bit seen;
    bus.req_valid = 1'b1;
    bus.req_mode  = m;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 10) begin
      @(negedge clk);
      cyc++;
      bus.req_valid = 1'b0;
      if (bus.rsp_valid) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL quick_req/timeout: got no rsp_valid, required one");
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_mode  = 3'd0;

    vecs[0]  = '{3'd2, 1'b0, 2,     3'd0, 8'd1};
    vecs[1]  = '{3'd6, 1'b0, 2,     3'd0, 8'd2};
    vecs[2]  = '{3'd1, 1'b1, LAT_S, 3'd1, 8'd2};
    vecs[3]  = '{3'd2, 1'b1, LAT_S, 3'd2, 8'd2};
    vecs[4]  = '{3'd2, 1'b1, 2,     3'd2, 8'd2};
    vecs[5]  = '{3'd1, 1'b0, 2,     3'd2, 8'd3};
    vecs[6]  = '{3'd3, 1'b1, LAT_S, 3'd3, 8'd3};
    vecs[7]  = '{3'd3, 1'b1, 2,     3'd3, 8'd3};
    vecs[8]  = '{3'd0, 1'b1, LAT_S, 3'd0, 8'd3};
    vecs[9]  = '{3'd0, 1'b1, 2,     3'd0, 8'd3};
    vecs[10] = '{3'd3, 1'b0, 2,     3'd0, 8'd4};
    vecs[11] = '{3'd4, 1'b0, 2,     3'd0, 8'd5};
    vecs[12] = '{3'd1, 1'b1, LAT_S, 3'd1, 8'd5};

    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_values("post_reset");

    for (int i = 0; i < 13; i++) begin
      do_req($sformatf("vec%0d", i), vecs[i].req, vecs[i].ok, vecs[i].lat,
             vecs[i].mode_after, vecs[i].err_after);
    end

    // Fault in the middle of SETTLE aborts the RUN->PAUSE request.
    do_req("to_run", 3'd2, 1'b1, LAT_S, 3'd2, 8'd5);
    bus.req_valid = 1'b1;
    bus.req_mode  = 3'd3;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("fault/pre_mode", 32'(mode), 32'd2);
    check("fault/pre_busy", 32'(busy), 32'd1);
    fault_in = 1'b1;
    @(negedge clk);
    check("fault/mode", 32'(mode), 32'd4);
    check("fault/rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("fault/rsp_ok", 32'(bus.rsp_ok), 32'd0);
    check("fault/err_cnt", 32'(err_cnt), 32'd5);
    @(negedge clk);
    check("fault/one_shot", 32'(bus.rsp_valid), 32'd0);
    do_req("fault_held_off", 3'd0, 1'b0, 2, 3'd4, 8'd5);
    fault_in = 1'b0;
    @(negedge clk);
    check("fault/hold_after_drop", 32'(mode), 32'd4);
    do_req("fault_to_off", 3'd0, 1'b1, LAT_S, 3'd0, 8'd5);

    // Corrupted mode register is pulled to FAULT without a response.
    force dut.mode_q = 3'd7;
    #1;
    check("integrity/forced", 32'(mode), 32'd7);
    release dut.mode_q;
    @(negedge clk);
    check("integrity/mode", 32'(mode), 32'd4);
    check("integrity/rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("integrity/busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("integrity/rsp_valid2", 32'(bus.rsp_valid), 32'd0);
    do_req("integrity_off", 3'd0, 1'b1, LAT_S, 3'd0, 8'd5);

    for (int i = 0; i < 300; i++) begin
      quick_req(3'd3);
      if (i == 248) check("sat/err_254", 32'(err_cnt), 32'd254);
      if (i == 249) check("sat/err_255", 32'(err_cnt), 32'd255);
    end
    check("sat/err_final", 32'(err_cnt), 32'd255);
    check("sat/mode", 32'(mode), 32'd0);

    // Reset asserted mid-SETTLE drops the request immediately.
    do_req("pre_rst_init", 3'd1, 1'b1, LAT_S, 3'd1, 8'd255);
    bus.req_valid = 1'b1;
    bus.req_mode  = 3'd2;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst/busy", 32'(busy), 32'd1);
    rst_n = 1'b1;
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("midrst/no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    check("midrst/mode", 32'(mode), 32'd0);
    do_req("post_rst_init", 3'd1, 1'b1, LAT_S, 3'd1, 8'd0);

`ifdef MODE_SEQ_LOCK_EN
    do_req("lock_run", 3'd2, 1'b1, LAT_S, 3'd2, 8'd0);
    check("lock/initial", 32'(locked), 32'd0);
    lock_req = 1'b1;
    @(negedge clk);
    lock_req = 1'b0;
    check("lock/set", 32'(locked), 32'd1);
    do_req("lock_pause", 3'd3, 1'b0, 2, 3'd2, 8'd1);
    do_req("lock_same", 3'd2, 1'b0, 2, 3'd2, 8'd2);
    check("lock/sticky", 32'(locked), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mode_sequencer.md
Name: mode_sequencer

Overview:
- Guarded controller for the system mode FSM.
- Requesters never write the mode register directly. They submit a requested mode through a valid/ready handshake.
- The block checks the request against a fixed legal-transition table, waits a settle interval, then commits the new mode and returns one response.
- Sits between software/user-facing request logic and the mode-dependent datapath.

Parameters:
SETTLE_CYCLES, 4, cycles spent in SETTLE before commit; legal range 1..255
ERR_W, 8, width of saturating error counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous reset, active-high (asserted = 1)
req_valid  input  1  request present
req_mode  input  3  requested mode
req_ready  output  1  block can accept request
fault_in  input  1  external fault, level-sensitive
mode  output  3  committed current mode
busy  output  1  request in flight (CHECK or SETTLE)
rsp_valid  output  1  one-cycle response strobe
rsp_ok  output  1  response result, valid with rsp_valid
err_cnt  output  ERR_W  count of rejected requests, saturating

Behaviour:
- Modes: OFF=0, INIT=1, RUN=2, PAUSE=3, FAULT=4. Codes 5..7 are undefined.
- Legal transitions: OFF->INIT, INIT->RUN, RUN->PAUSE, PAUSE->RUN, any->OFF. Everything else is illegal, including any target of FAULT or 5..7.
- Reset values: mode=OFF, ctrl=IDLE, req_ready=1, busy=0, rsp_valid=0, rsp_ok=0, err_cnt=0, settle counter=0.
- Controller states: IDLE, CHECK, SETTLE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, capture req_mode into pend_mode and go to CHECK.
  - req_ready=0 in all other states.
- CHECK (1 cycle):
  - pend==mode: go to RESP with ok=1; no settle; err_cnt unchanged.
  - Legal: load counter=SETTLE_CYCLES-1 and go to SETTLE.
  - Illegal: go to RESP with ok=0; err_cnt+1, saturating at all-ones.
- SETTLE:
  - Decrement the counter each cycle.
  - At the cycle where counter==0: mode<=pend_mode at that edge, then go to RESP with ok=1.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE.
- Latency, with accept in cycle T:
  - Illegal or same-mode: rsp_valid in T+2.
  - Legal: mode changes at the end of T+1+SETTLE_CYCLES; rsp_valid in T+2+SETTLE_CYCLES.
- fault_in has highest priority, in any state:
  - mode<=FAULT at the next edge.
  - If in CHECK or SETTLE: abort, go to RESP with ok=0; err_cnt unchanged.
  - If in IDLE or RESP: behave normally, but the commit is suppressed.
  - While fault_in stays high, mode holds FAULT; requests are accepted and rejected (only OFF is legal, and it cannot commit while fault_in=1, so RESP ok=0).
- Integrity: if the mode register ever holds 5..7, it is forced to FAULT on the next edge with no response generated.
- Reset mid-operation: everything returns immediately to reset values; the pending request is dropped with no response.
- rsp_ok is 0 whenever rsp_valid=0.

Optional Feature:
MODE_SEQ_LOCK_EN
- Defined:
  - Adds input lock_req (1) and output locked (1).
  - lock_req=1 while mode==RUN and ctrl==IDLE sets locked=1. locked is sticky until reset.
  - While locked, every request, including same-mode, is rejected in CHECK with ok=0 and err_cnt+1.
  - fault_in still forces FAULT.
- Undefined: both ports are absent and no lock logic exists.

Decomposition:
- Package mode_seq_pkg holds:
  - mode_t enum (3-bit) and ctrl_state_t enum.
  - Constants MODE_OFF..MODE_FAULT.
  - Pure function is_legal(cur,nxt).
- One natural sub-module: settle_timer, a loadable down-counter with a zero flag, width $clog2(SETTLE_CYCLES+1).

Test Plan:
- Reset then req OFF->INIT->RUN, SETTLE_CYCLES=4 -> each rsp_ok=1 at T+6; mode=1 then 2; err_cnt=0.
- From OFF, request RUN (2) -> rsp_ok=0 at T+2; mode stays 0; err_cnt=1. Request 6 -> rejected; err_cnt=2.
- Mode RUN, request PAUSE, assert fault_in at T+3 -> mode=FAULT at T+4, rsp_valid with ok=0 at T+4. Then drop fault and request OFF -> ok=1, mode=0.
- Force the mode register to 7 via force/release -> mode=4 next cycle, rsp_valid stays 0.
- Issue 300 illegal requests with ERR_W=8 -> err_cnt saturates at 255. Assert rst_n=1 mid-SETTLE -> all outputs at reset values the same cycle.
- With MODE_SEQ_LOCK_EN: in RUN, pulse lock_req -> locked=1. Request PAUSE -> ok=0, err_cnt+1, mode stays 2.
